fht_input_loader: RTL and testbench

FHT_INPUT_LOADER -- requirements
Module: fht_input_loader

---
 rtl/fht_input_loader_pkg.sv | 18 +
 rtl/fht_input_loader_bit_rev.sv | 14 +
 rtl/fht_input_loader.sv | 84 ++++++++
 tb/tb_fht_input_loader.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fht_input_loader_pkg.sv
// Shared FHT defines: frame geometry, bank count and bank one-hot decode.
// Used by both the input loader and the FHT controller.
package fht_input_loader_pkg;

    localparam int FHT_A_BIT    = 8;
    localparam int FHT_BANKS    = 4;
    localparam int FHT_BANK_BIT = 2;
    localparam int FHT_N        = FHT_BANKS << FHT_A_BIT;

    function automatic int fht_frame_len(input int a_bit);
        return FHT_BANKS << a_bit;
    endfunction

    function automatic logic [FHT_BANKS-1:0] fht_bank_sel(input logic [FHT_BANK_BIT-1:0] bank);
        return {{(FHT_BANKS-1){1'b0}}, 1'b1} << bank;
    endfunction

endpackage

// File: rtl/fht_input_loader_bit_rev.sv
// Combinational bit-reverser: rev_dat[i] = bits_dat[W-1-i].
// Zero latency, no flow control.
module fht_bit_rev #(
    parameter int W = 10
) (
    input  logic [W-1:0] bits_dat,
    output logic [W-1:0] rev_dat
);

    for (genvar i = 0; i < W; i++) begin : g_rev
        assign rev_dat[i] = bits_dat[W-1-i];
    end

endmodule

// File: rtl/fht_input_loader.sv
// Loads a natural-order sample stream into four RAM banks in bit-reversed order,
// then hands the frame to the FHT controller (1-cycle registered write, oSTART after last write).
// Backpressure: oREADY is high only in LOAD; samples offered at any other time are dropped.
module fht_input_loader
    import fht_input_loader_pkg::*;
#(
    parameter int A_BIT = FHT_A_BIT,
    parameter int D_BIT = 16
) (
    input  logic                 iCLK,
    input  logic                 iRESET,
    input  logic                 iVALID,
    input  logic [D_BIT-1:0]     iDATA,
    output logic                 oREADY,
    input  logic                 iFHT_RDY,
    output logic                 oSTART,
    output logic [FHT_BANKS-1:0] oWE,
    output logic [A_BIT-1:0]     oADDR_WR,
    output logic [D_BIT-1:0]     oDATA,
    output logic                 oBUSY
);

    localparam int NW = A_BIT + FHT_BANK_BIT;
    localparam logic [NW-1:0] N_LAST = NW'(fht_frame_len(A_BIT) - 1);

    localparam logic [1:0] ST_LOAD      = 2'd0;
    localparam logic [1:0] ST_START     = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    logic [1:0]    state;
    logic [NW-1:0] cnt;
    logic [NW-1:0] rev;
    logic          accept;

    // Ready is masked during reset so every output reads 0 while iRESET is high.
    assign oREADY = (state == ST_LOAD) && !iRESET;
    assign oBUSY  = (state != ST_LOAD);
    assign accept = iVALID && oREADY;

    fht_bit_rev #(.W(NW)) u_bit_rev (
        .bits_dat (cnt),
        .rev_dat  (rev)
    );

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state <= ST_LOAD;
            cnt   <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        cnt <= (cnt == N_LAST) ? '0 : cnt + 1'b1;
                        if (cnt == N_LAST) state <= ST_START;
                    end
                end
                ST_START:     state <= ST_WAIT_ACK;
                ST_WAIT_ACK:  if (!iFHT_RDY) state <= ST_WAIT_DONE;
                ST_WAIT_DONE: if (iFHT_RDY) state <= ST_LOAD;
                default:      state <= ST_LOAD;
            endcase
        end
    end

    // oSTART is registered off START, so it lands one cycle after the final oWE.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            oWE      <= '0;
            oADDR_WR <= '0;
            oDATA    <= '0;
            oSTART   <= 1'b0;
        end else begin
            oWE    <= '0;
            oSTART <= (state == ST_START);
            if (accept) begin
                oWE      <= fht_bank_sel(rev[NW-1:A_BIT]);
                oADDR_WR <= rev[A_BIT-1:0];
                oDATA    <= iDATA;
            end
        end
    end

endmodule

// File: tb/tb_fht_input_loader.sv
// Randomized bench for fht_input_loader against a bit-reversal reference model.
module tb_fht_input_loader;

    localparam int ABITS = 8;
    localparam int DBITS = 16;
    localparam int NW    = ABITS + 2;
    localparam int NPTS  = 1 << NW;

    logic             iCLK;
    logic             iRESET;
    logic             iVALID;
    logic [DBITS-1:0] iDATA;
    logic             oREADY;
    logic             iFHT_RDY;
    logic             oSTART;
    logic [3:0]       oWE;
    logic [ABITS-1:0] oADDR_WR;
    logic [DBITS-1:0] oDATA;
    logic             oBUSY;

    fht_input_loader #(.A_BIT(ABITS), .D_BIT(DBITS)) dut (
        .iCLK     (iCLK),
        .iRESET   (iRESET),
        .iVALID   (iVALID),
        .iDATA    (iDATA),
        .oREADY   (oREADY),
        .iFHT_RDY (iFHT_RDY),
        .oSTART   (oSTART),
        .oWE      (oWE),
        .oADDR_WR (oADDR_WR),
        .oDATA    (oDATA),
        .oBUSY    (oBUSY)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int errors = 0;
    int checks = 0;
    int acc_n  = 0;          // model: index of the next sample to be accepted
    bit record = 1'b0;
    int seen     [NPTS];
    int obs_we   [NPTS];
    int obs_addr [NPTS];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: reverse n over NW bits, high 2 bits select the bank.
    function automatic int rev_n(input int n);
        int r = 0;
        for (int i = 0; i < NW; i++) r = r * 2 + ((n >> i) & 1);
        return r;
    endfunction

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic run_samples(input int count, input int gap_pct);
        int done  = 0;
        int guard = 0;
        bit v;
        int r;
        int d;
        while (done < count && guard < 20000) begin
            check("ready_in_load", 32'(oREADY), 1);
            v = ($urandom_range(0, 99) >= gap_pct);
            d = int'($urandom_range(0, 65535));
            iVALID = v;
            iDATA  = DBITS'(d);
            tick();
            guard++;
            check("start_low_in_frame", 32'(oSTART), 0);
            if (v) begin
                r = rev_n(acc_n);
                check("we", 32'(oWE), 1 << (r / (1 << ABITS)));
                check("addr", 32'(oADDR_WR), r % (1 << ABITS));
                check("data", 32'(oDATA), d);
                if (record) begin
                    seen[{oWE[3] | oWE[2], oWE[3] | oWE[1], oADDR_WR} & (NPTS-1)]++;
                    obs_we[acc_n]   = 32'(oWE);
                    obs_addr[acc_n] = 32'(oADDR_WR);
                end
                acc_n = (acc_n + 1) % NPTS;
                done++;
            end else begin
                check("we_idle", 32'(oWE), 0);
            end
        end
        iVALID = 1'b0;
        if (done < count) check("sample_timeout", done, count);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},    32'(oWE), 0);
        check({tag, "_addr"},  32'(oADDR_WR), 0);
        check({tag, "_data"},  32'(oDATA), 0);
        check({tag, "_start"}, 32'(oSTART), 0);
        check({tag, "_busy"},  32'(oBUSY), 0);
        check({tag, "_ready"}, 32'(oREADY), 0);
    endtask

    initial begin
        int bad;
        iRESET = 1'b1; iVALID = 1'b0; iDATA = '0; iFHT_RDY = 1'b1;
        for (int i = 0; i < NPTS; i++) begin
            seen[i] = 0; obs_we[i] = 0; obs_addr[i] = 0;
        end
        tick(); tick();
        check_reset_outputs("reset");
        iRESET = 1'b0;
        #1;
        check("ready_after_reset", 32'(oREADY), 1);
        check("busy_after_reset", 32'(oBUSY), 0);

        // Frame 1 with random valid gaps
        record = 1'b1;
        run_samples(NPTS, 30);
        record = 1'b0;
        check("last_we_cycle_ready", 32'(oREADY), 0);
        check("last_we_cycle_start", 32'(oSTART), 0);
        check("last_we_cycle_busy", 32'(oBUSY), 1);

        bad = 0;
        for (int i = 0; i < NPTS; i++) if (seen[i] != 1) bad++;
        check("slots_not_written_once", bad, 0);
        check("n1_we", obs_we[1], 4);       check("n1_addr", obs_addr[1], 0);
        check("n3_we", obs_we[3], 8);       check("n3_addr", obs_addr[3], 0);
        check("n4_we", obs_we[4], 1);       check("n4_addr", obs_addr[4], 128);
        check("n1023_we", obs_we[1023], 8); check("n1023_addr", obs_addr[1023], 255);

        // Samples offered through the whole handshake must be ignored
        iVALID = 1'b1; iDATA = 16'h5a5a;
        tick();
        check("start_pulse", 32'(oSTART), 1);
        check("start_we", 32'(oWE), 0);
        check("start_ready", 32'(oREADY), 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("wait_ack_start", 32'(oSTART), 0);
            check("wait_ack_ready", 32'(oREADY), 0);
            check("wait_ack_busy", 32'(oBUSY), 1);
            check("wait_ack_we", 32'(oWE), 0);
        end
        iFHT_RDY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("wait_done_ready", 32'(oREADY), 0);
            check("wait_done_busy", 32'(oBUSY), 1);
            check("wait_done_we", 32'(oWE), 0);
        end
        iFHT_RDY = 1'b1;
        tick();
        check("reload_ready", 32'(oREADY), 1);
        check("reload_busy", 32'(oBUSY), 0);
        check("reload_we", 32'(oWE), 0);
        iVALID = 1'b0;

        // Frame 2 must restart at n = 0; then reset mid-frame
        check("frame2_model_n", acc_n, 0);
        run_samples(500, 20);
        iRESET = 1'b1;
        #1;
        check_reset_outputs("midreset");
        iVALID = 1'b1;
        tick();
        check_reset_outputs("midreset_hold");
        iVALID = 1'b0;
        iRESET = 1'b0;
        acc_n  = 0;
        #1;
        iVALID = 1'b1; iDATA = 16'h1234;
        tick();
        check("post_reset_we", 32'(oWE), 1);
        check("post_reset_addr", 32'(oADDR_WR), 0);
        check("post_reset_data", 32'(oDATA), 32'h1234);
        acc_n  = 1;
        iVALID = 1'b0;
        run_samples(16, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
